adc_ddr_word_align: RTL and testbench

- Sits directly downstream of the ADS5400 input-capture stage.
- Consumes the 12 lanes x 2 bits (Q1/Q2) that the ISERDES produce per clk250 cycle and rebuilds two 12-bit ADC samples per cycle.
- Determines the Q1/Q2 sample ordering with a training FSM driven by the ADC's alternating test pattern.
- Delivers aligned, two's-complement sample pairs plus lock status to the DSP chain; one instance per ADC channel (A, B).

---
 rtl/adc_align_pkg.sv | 32 +++
 rtl/adc_align_fsm.sv | 137 +++++++++++++
 rtl/adc_ddr_word_align.sv | 91 +++++++++
 tb/tb_adc_ddr_word_align.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_align_pkg.sv
// Shared types and constants for the ADS5400 DDR word-alignment block.
package adc_align_pkg;

    localparam int unsigned ADC_BITS = 12;

    localparam logic [ADC_BITS-1:0] PAT_A_DEF = 12'hAAA;
    localparam logic [ADC_BITS-1:0] PAT_B_DEF = 12'h555;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_LOCKED,
        ST_FAIL
    } align_state_e;

    // A lane is flagged only when it is wrong under both the forward and the
    // reversed Q1/Q2 ordering, so a plain ordering mix-up never marks a lane.
    function automatic logic [ADC_BITS-1:0] lanes_wrong_both(
        input logic [ADC_BITS-1:0] q1,
        input logic [ADC_BITS-1:0] q2,
        input logic [ADC_BITS-1:0] pat_a,
        input logic [ADC_BITS-1:0] pat_b
    );
        logic [ADC_BITS-1:0] wrong_fwd;
        logic [ADC_BITS-1:0] wrong_rev;
        wrong_fwd = (q1 ^ pat_a) | (q2 ^ pat_b);
        wrong_rev = (q1 ^ pat_b) | (q2 ^ pat_a);
        return wrong_fwd & wrong_rev;
    endfunction

endpackage

// File: rtl/adc_align_fsm.sv
// Training FSM: finds the Q1/Q2 ordering from the ADC alternating test
// pattern, tracks per-lane errors and reports lock / failure.
module adc_align_fsm
    import adc_align_pkg::*;
#(
    parameter logic [ADC_BITS-1:0] PAT_A       = PAT_A_DEF,
    parameter logic [ADC_BITS-1:0] PAT_B       = PAT_B_DEF,
    parameter int unsigned         SETTLE_CYC  = 16,
    parameter int unsigned         MATCH_CYC   = 64,
    parameter int unsigned         TIMEOUT_CYC = 4096
) (
    input  logic                clk250,
    input  logic                rst,
    input  logic [ADC_BITS-1:0] q1_s1,
    input  logic [ADC_BITS-1:0] q2_s1,
    input  logic                train_start,
    output logic                locked,
    output logic                train_fail,
    output logic                swap,
    output logic [ADC_BITS-1:0] lane_err
);

    localparam int unsigned SETTLE_W  = $clog2(SETTLE_CYC) + 1;
    localparam int unsigned MATCH_W   = $clog2(MATCH_CYC) + 1;
    localparam int unsigned TIMEOUT_W = $clog2(TIMEOUT_CYC) + 1;

    align_state_e          state_q, state_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
    logic [TIMEOUT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
    logic                  cand_valid_q, cand_valid_d;
    logic                  cand_swap_q, cand_swap_d;
    logic                  swap_q, swap_d;
    logic [ADC_BITS-1:0]   lane_err_q, lane_err_d;

    logic fwd;
    logic rev;
    logic hit;

    // State and counter registers.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            match_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            cand_valid_q  <= 1'b0;
            cand_swap_q   <= 1'b0;
            swap_q        <= 1'b0;
            lane_err_q    <= '0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            match_cnt_q   <= match_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            cand_valid_q  <= cand_valid_d;
            cand_swap_q   <= cand_swap_d;
            swap_q        <= swap_d;
            lane_err_q    <= lane_err_d;
        end
    end

    // Next-state logic; timeout is tested before lock so it wins a tie.
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        match_cnt_d   = match_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        cand_valid_d  = cand_valid_q;
        cand_swap_d   = cand_swap_q;
        swap_d        = swap_q;
        lane_err_d    = lane_err_q;

        fwd = (q1_s1 == PAT_A) && (q2_s1 == PAT_B);
        rev = (q1_s1 == PAT_B) && (q2_s1 == PAT_A);
        hit = cand_valid_q ? (cand_swap_q ? rev : fwd) : (fwd || rev);

        if (train_start) begin
            state_d       = ST_SETTLE;
            settle_cnt_d  = '0;
            match_cnt_d   = '0;
            timeout_cnt_d = '0;
            cand_valid_d  = 1'b0;
            cand_swap_d   = 1'b0;
            lane_err_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_SETTLE: begin
                    settle_cnt_d  = settle_cnt_q + SETTLE_W'(1);
                    timeout_cnt_d = timeout_cnt_q + TIMEOUT_W'(1);
                    if (timeout_cnt_d == TIMEOUT_W'(TIMEOUT_CYC)) begin
                        state_d = ST_FAIL;
                    end else if (settle_cnt_d == SETTLE_W'(SETTLE_CYC)) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    timeout_cnt_d = timeout_cnt_q + TIMEOUT_W'(1);
                    if (hit) begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                        if (!cand_valid_q) begin
                            cand_valid_d = 1'b1;
                            cand_swap_d  = !fwd;
                        end
                    end else begin
                        match_cnt_d  = '0;
                        cand_valid_d = 1'b0;
                        cand_swap_d  = 1'b0;
                        lane_err_d   = lane_err_q |
                                       lanes_wrong_both(q1_s1, q2_s1, PAT_A, PAT_B);
                    end
                    if (timeout_cnt_d == TIMEOUT_W'(TIMEOUT_CYC)) begin
                        state_d = ST_FAIL;
                    end else if (hit && (match_cnt_d == MATCH_W'(MATCH_CYC))) begin
                        state_d = ST_LOCKED;
                        swap_d  = cand_swap_d;
                    end
                end
                ST_LOCKED: begin
                end
                ST_FAIL: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign train_fail = (state_q == ST_FAIL);
    assign swap       = swap_q;
    assign lane_err   = lane_err_q;

endmodule

// File: rtl/adc_ddr_word_align.sv
// Rebuilds aligned two's-complement sample pairs from the 12 ISERDES lanes
// (Q1/Q2 per lane) and reports training status.
module adc_ddr_word_align
    import adc_align_pkg::*;
#(
    parameter logic [ADC_BITS-1:0] PAT_A       = PAT_A_DEF,
    parameter logic [ADC_BITS-1:0] PAT_B       = PAT_B_DEF,
    parameter int unsigned         SETTLE_CYC  = 16,
    parameter int unsigned         MATCH_CYC   = 64,
    parameter int unsigned         TIMEOUT_CYC = 4096,
    parameter int unsigned         TWOS_COMP   = 1
) (
    input  logic                clk250,
    input  logic                rst,
    input  logic [ADC_BITS-1:0] q1_bits,
    input  logic [ADC_BITS-1:0] q2_bits,
    input  logic                train_start,
    output logic [ADC_BITS-1:0] sample_even,
    output logic [ADC_BITS-1:0] sample_odd,
    output logic                sample_valid,
    output logic                locked,
    output logic                train_fail,
    output logic                swap,
    output logic [ADC_BITS-1:0] lane_err
);

    localparam logic [ADC_BITS-1:0] MSB_FLIP =
        (TWOS_COMP != 0) ? {1'b1, {(ADC_BITS-1){1'b0}}} : '0;

    logic [ADC_BITS-1:0] q1_s1_q, q1_s1_d;
    logic [ADC_BITS-1:0] q2_s1_q, q2_s1_d;
    logic [ADC_BITS-1:0] sample_even_q, sample_even_d;
    logic [ADC_BITS-1:0] sample_odd_q, sample_odd_d;
    logic                sample_valid_q, sample_valid_d;

    logic                fsm_locked;
    logic                fsm_swap;

    adc_align_fsm #(
        .PAT_A       (PAT_A),
        .PAT_B       (PAT_B),
        .SETTLE_CYC  (SETTLE_CYC),
        .MATCH_CYC   (MATCH_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk250      (clk250),
        .rst         (rst),
        .q1_s1       (q1_s1_q),
        .q2_s1       (q2_s1_q),
        .train_start (train_start),
        .locked      (fsm_locked),
        .train_fail  (train_fail),
        .swap        (fsm_swap),
        .lane_err    (lane_err)
    );

    // Stage-1 capture and stage-2 ordering/format selection.
    always_comb begin
        q1_s1_d       = q1_bits;
        q2_s1_d       = q2_bits;
        sample_even_d = (fsm_swap ? q2_s1_q : q1_s1_q) ^ MSB_FLIP;
        sample_odd_d  = (fsm_swap ? q1_s1_q : q2_s1_q) ^ MSB_FLIP;
        // Trails locked by one cycle to line up with the data, but drops on
        // the same edge as locked when training restarts.
        sample_valid_d = fsm_locked && !train_start;
    end

    // Two-stage data pipeline registers.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            q1_s1_q        <= '0;
            q2_s1_q        <= '0;
            sample_even_q  <= '0;
            sample_odd_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            q1_s1_q        <= q1_s1_d;
            q2_s1_q        <= q2_s1_d;
            sample_even_q  <= sample_even_d;
            sample_odd_q   <= sample_odd_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample_even  = sample_even_q;
    assign sample_odd   = sample_odd_q;
    assign sample_valid = sample_valid_q;
    assign locked       = fsm_locked;
    assign swap         = fsm_swap;

endmodule

// File: tb/tb_adc_ddr_word_align.sv
// Directed bench for adc_ddr_word_align: data-path vector table plus
// hand-written training, glitch, stuck-lane and async-reset sequences.
`timescale 1ns/100ps
module tb_adc_ddr_word_align;

    logic        clk250 = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] q1_bits = 12'hAAA;
    logic [11:0] q2_bits = 12'h555;
    logic        train_start = 1'b0;
    logic [11:0] sample_even;
    logic [11:0] sample_odd;
    logic        sample_valid;
    logic        locked;
    logic        train_fail;
    logic        swap;
    logic [11:0] lane_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        sw;
        logic [11:0] q1;
        logic [11:0] q2;
        logic [11:0] even;
        logic [11:0] odd;
    } vec_t;

    vec_t vecs [6];

    adc_ddr_word_align #(
        .PAT_A       (12'hAAA),
        .PAT_B       (12'h555),
        .SETTLE_CYC  (16),
        .MATCH_CYC   (64),
        .TIMEOUT_CYC (4096),
        .TWOS_COMP   (1)
    ) dut (
        .clk250       (clk250),
        .rst          (rst),
        .q1_bits      (q1_bits),
        .q2_bits      (q2_bits),
        .train_start  (train_start),
        .sample_even  (sample_even),
        .sample_odd   (sample_odd),
        .sample_valid (sample_valid),
        .locked       (locked),
        .train_fail   (train_fail),
        .swap         (swap),
        .lane_err     (lane_err)
    );

    always #5 clk250 = ~clk250;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk250);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_train();
        train_start = 1'b1;
        tick(1);
        train_start = 1'b0;
    endtask

    // Pulse at edge E0: SETTLE for E1..E16, CHECK matches E17..E80,
    // locked visible after E80, sample_valid after E81.
    task automatic train_and_lock(input logic [11:0] a, input logic [11:0] b,
                                  input logic exp_swap, input string tag);
        q1_bits = a;
        q2_bits = b;
        pulse_train();
        chk({tag, "_locked_drop"}, 32'(locked), 0);
        chk({tag, "_valid_drop"}, 32'(sample_valid), 0);
        chk({tag, "_fail_drop"}, 32'(train_fail), 0);
        tick(79);
        chk({tag, "_locked_early"}, 32'(locked), 0);
        tick(1);
        chk({tag, "_locked"}, 32'(locked), 1);
        chk({tag, "_swap"}, 32'(swap), 32'(exp_swap));
        chk({tag, "_lane_err"}, 32'(lane_err), 0);
        chk({tag, "_train_fail"}, 32'(train_fail), 0);
        chk({tag, "_valid_lag"}, 32'(sample_valid), 0);
        tick(1);
        chk({tag, "_valid"}, 32'(sample_valid), 1);
    endtask

    initial begin
        logic        cur_swap;
        logic [11:0] prev_e;
        logic [11:0] prev_o;

        vecs[0] = '{1'b0, 12'h000, 12'hFFF, 12'h800, 12'h7FF};
        vecs[1] = '{1'b0, 12'h123, 12'hABC, 12'h923, 12'h2BC};
        vecs[2] = '{1'b0, 12'h7FF, 12'h800, 12'hFFF, 12'h000};
        vecs[3] = '{1'b1, 12'h000, 12'hFFF, 12'h7FF, 12'h800};
        vecs[4] = '{1'b1, 12'h123, 12'hABC, 12'h2BC, 12'h923};
        vecs[5] = '{1'b1, 12'hF0F, 12'h0F0, 12'h8F0, 12'h70F};

        // Reset state
        tick(3);
        chk("rst_even", 32'(sample_even), 0);
        chk("rst_odd", 32'(sample_odd), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fail", 32'(train_fail), 0);
        chk("rst_swap", 32'(swap), 0);
        chk("rst_lane_err", 32'(lane_err), 0);
        #2;
        rst = 1'b0;
        tick(2);

        // Forward lock
        train_and_lock(12'hAAA, 12'h555, 1'b0, "fwd");

        // Data-path table; a swap change in the table retrains from LOCKED.
        // Pattern words AAA/555 map to 2AA/D55 in either ordering.
        cur_swap = 1'b0;
        prev_e = 12'h2AA;
        prev_o = 12'hD55;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].sw != cur_swap) begin
                train_and_lock(vecs[i].sw ? 12'h555 : 12'hAAA,
                               vecs[i].sw ? 12'hAAA : 12'h555,
                               vecs[i].sw, "retrain");
                cur_swap = vecs[i].sw;
                prev_e = 12'h2AA;
                prev_o = 12'hD55;
            end
            q1_bits = vecs[i].q1;
            q2_bits = vecs[i].q2;
            tick(1);
            chk($sformatf("vec%0d_even_lat1", i), 32'(sample_even), 32'(prev_e));
            chk($sformatf("vec%0d_odd_lat1", i), 32'(sample_odd), 32'(prev_o));
            tick(1);
            chk($sformatf("vec%0d_even", i), 32'(sample_even), 32'(vecs[i].even));
            chk($sformatf("vec%0d_odd", i), 32'(sample_odd), 32'(vecs[i].odd));
            chk($sformatf("vec%0d_valid", i), 32'(sample_valid), 1);
            prev_e = vecs[i].even;
            prev_o = vecs[i].odd;
        end

        // Async reset mid-CHECK (swap is 1 and samples nonzero beforehand)
        q1_bits = 12'h555;
        q2_bits = 12'hAAA;
        pulse_train();
        tick(30);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_even", 32'(sample_even), 0);
        chk("arst_odd", 32'(sample_odd), 0);
        chk("arst_valid", 32'(sample_valid), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_fail", 32'(train_fail), 0);
        chk("arst_swap", 32'(swap), 0);
        chk("arst_lane_err", 32'(lane_err), 0);
        #2;
        rst = 1'b0;
        tick(200);
        chk("arst_idle_locked", 32'(locked), 0);
        chk("arst_idle_fail", 32'(train_fail), 0);
        chk("arst_idle_valid", 32'(sample_valid), 0);

        // Stuck lane 5 low: forward words become A8A/555
        q1_bits = 12'hA8A;
        q2_bits = 12'h555;
        pulse_train();
        tick(4095);
        chk("stuck_fail_early", 32'(train_fail), 0);
        chk("stuck_locked_early", 32'(locked), 0);
        tick(1);
        chk("stuck_fail", 32'(train_fail), 1);
        chk("stuck_locked", 32'(locked), 0);
        chk("stuck_lane_err", 32'(lane_err), 32'h020);
        chk("stuck_valid", 32'(sample_valid), 0);

        // Glitch at match count 40: seen by the FSM at E57, lock at E121
        q1_bits = 12'hAAA;
        q2_bits = 12'h555;
        pulse_train();
        chk("glitch_fail_drop", 32'(train_fail), 0);
        chk("glitch_lane_err_clr", 32'(lane_err), 0);
        tick(55);
        q1_bits = 12'h000;
        q2_bits = 12'h000;
        tick(1);
        q1_bits = 12'hAAA;
        q2_bits = 12'h555;
        tick(24);
        chk("glitch_no_lock_e80", 32'(locked), 0);
        tick(40);
        chk("glitch_no_lock_e120", 32'(locked), 0);
        tick(1);
        chk("glitch_lock_e121", 32'(locked), 1);
        chk("glitch_swap", 32'(swap), 0);
        chk("glitch_lane_err", 32'(lane_err), 32'hFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
